// File: rtl/tm_pkg.sv
// Shared sizing defaults and state encoding for the task-memory loader.
package tm_pkg;

   localparam int INSN_SIZE      = 16;
   localparam int INSN_COUNT     = 16;
   localparam int TASK_MEM_DEPTH = 8;
   localparam int TASK_MEM_WIDTH = INSN_COUNT * INSN_SIZE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FILL = 2'd2,
      ST_DONE = 2'd3
   } tm_state_t;

endpackage

// File: rtl/tm_loader_addr_ctr.sv
// Row/column slot pointer into task memory; wraps col into row and flags the
// last slot. Shared by word loading and zero filling.
module tm_loader_addr_ctr #(
   parameter  int ROWS = 8,
   parameter  int COLS = 16,
   localparam int SW   = $clog2(ROWS * COLS)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [SW-1:0] o_slot,
   output logic          o_final
);

   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

   logic [RW-1:0]  r_row;
   logic [CLW-1:0] r_col;
   logic           w_col_end;
   logic           w_row_end;

   assign w_col_end = (r_col == CLW'(COLS - 1));
   assign w_row_end = (r_row == RW'(ROWS - 1));
   assign o_final   = w_col_end && w_row_end;
   assign o_slot    = SW'(r_row) * SW'(COLS) + SW'(r_col);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_inc) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tm_loader.sv
// Streams instruction words into a flat task-memory image for the scheduler.
// Define TM_LOADER_ZERO_FILL_EN to zero the unused tail after in_last.
module tm_loader #(
   parameter int INSN_SIZE      = tm_pkg::INSN_SIZE,
   parameter int INSN_COUNT     = tm_pkg::INSN_COUNT,
   parameter int TASK_MEM_DEPTH = tm_pkg::TASK_MEM_DEPTH
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          start_load,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [INSN_SIZE-1:0]                          in_data,
   input  logic                                          in_last,
   output logic [TASK_MEM_DEPTH*INSN_COUNT*INSN_SIZE-1:0] task_memory,
   output logic                                          tm_valid,
   output logic                                          load_busy,
   output logic [$clog2(TASK_MEM_DEPTH*INSN_COUNT+1)-1:0] word_count,
   output logic                                          err_overflow
);

   import tm_pkg::*;

   localparam int SLOTS = TASK_MEM_DEPTH * INSN_COUNT;
   localparam int SW    = $clog2(SLOTS);
   localparam int MW    = $clog2(SLOTS * INSN_SIZE);
   localparam int CW    = $clog2(SLOTS + 1);

`ifdef TM_LOADER_ZERO_FILL_EN
   localparam tm_state_t ST_AFTER_LAST = ST_FILL;
`else
   localparam tm_state_t ST_AFTER_LAST = ST_DONE;
`endif

   tm_state_t              r_state;
   tm_state_t              w_next;
   logic [SLOTS*INSN_SIZE-1:0] r_mem;
   logic [CW-1:0]          r_cnt;
   logic                   r_err;
   logic [SW-1:0]          w_slot;
   logic [MW-1:0]          w_base;
   logic                   w_final;
   logic                   w_accept;
   logic                   w_fill_step;

   assign in_ready     = (r_state == ST_LOAD) && !start_load;
   assign w_accept     = in_valid && in_ready;
`ifdef TM_LOADER_ZERO_FILL_EN
   assign w_fill_step  = (r_state == ST_FILL) && !start_load;
`else
   assign w_fill_step  = 1'b0;
`endif
   assign w_base       = MW'(w_slot) * MW'(INSN_SIZE);

   assign task_memory  = r_mem;
   assign tm_valid     = (r_state == ST_DONE);
   assign load_busy    = (r_state == ST_LOAD) || (r_state == ST_FILL);
   assign word_count   = r_cnt;
   assign err_overflow = r_err;

   tm_loader_addr_ctr #(
      .ROWS (TASK_MEM_DEPTH),
      .COLS (INSN_COUNT)
   ) u_addr (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_clr   (start_load),
      .i_inc   (w_accept || w_fill_step),
      .o_slot  (w_slot),
      .o_final (w_final)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // start_load wins over everything, including a word presented the same cycle
   always_comb begin
      w_next = r_state;
      if (start_load) begin
         w_next = ST_LOAD;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_accept) begin
                  if (w_final)      w_next = ST_DONE;
                  else if (in_last) w_next = ST_AFTER_LAST;
               end
            end
`ifdef TM_LOADER_ZERO_FILL_EN
            ST_FILL: if (w_final) w_next = ST_DONE;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (start_load) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= r_cnt + 1'b1;
         if (w_final && !in_last) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           r_mem <= '0;
      else if (w_accept)    r_mem[w_base +: INSN_SIZE] <= in_data;
      else if (w_fill_step) r_mem[w_base +: INSN_SIZE] <= '0;
   end

endmodule

// File: doc/tm_loader.md
TM_LOADER -- requirements
Module: tm_loader

Interface
REQ-001 SHALL have parameter INSN_SIZE, default 16, bits per instruction word.
REQ-002 SHALL have parameter INSN_COUNT, default 16, instructions per task-memory row.
REQ-003 SHALL have parameter TASK_MEM_DEPTH, default 8, rows of task memory.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_load  input  1  pulse that begins or restarts a program load.
REQ-007 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have port in_data  input  INSN_SIZE  instruction word.
REQ-010 SHALL have port in_last  input  1  marks the final word of the program.
REQ-011 SHALL have port task_memory  output  TASK_MEM_DEPTH*INSN_COUNT*INSN_SIZE  flat image for Task_Scheduler; row r, insn k at bits [(k+1)*INSN_SIZE + r*INSN_COUNT*INSN_SIZE - 1 : k*INSN_SIZE + r*INSN_COUNT*INSN_SIZE].
REQ-012 SHALL have port tm_valid  output  1  image complete and stable.
REQ-013 SHALL have port load_busy  output  1  high in LOAD or FILL.
REQ-014 SHALL have port word_count  output  $clog2(TASK_MEM_DEPTH*INSN_COUNT+1)  words accepted since the last start_load.
REQ-015 SHALL have port err_overflow  output  1  sticky: memory filled before in_last.

Function
REQ-016 SHALL implement states IDLE, LOAD, FILL, DONE.
REQ-017 start_load in any state SHALL, next cycle, enter LOAD with row=0, col=0, word_count=0, err_overflow=0, tm_valid=0.
REQ-018 in_ready SHALL equal (state==LOAD) && !start_load; a word is accepted when in_valid && in_ready.
REQ-019 An accepted word SHALL be written to (row,col) and visible on task_memory the following cycle; word_count increments by 1.
REQ-020 col SHALL increment per accepted word, wrapping from INSN_COUNT-1 to 0 with row incrementing.
REQ-021 Accepted word with in_last and slot not final SHALL go to FILL (macro defined) or DONE (macro undefined).
REQ-022 Accepted word at final slot (row TASK_MEM_DEPTH-1, col INSN_COUNT-1) SHALL go to DONE regardless of in_last; err_overflow set if in_last was low.
REQ-023 FILL SHALL zero one slot per cycle from the slot after the last word through the final slot, then go to DONE; word_count unchanged.
REQ-024 tm_valid SHALL be 1 only in DONE; DONE holds until start_load.
REQ-025 start_load coincident with in_valid in LOAD SHALL restart; the word is not accepted.
REQ-026 in_valid outside LOAD SHALL be ignored with no state change.
REQ-027 Slots not written in a load SHALL keep prior contents (macro undefined).

Reset
REQ-028 reset low SHALL immediately force IDLE, all task_memory bits 0, in_ready=0, tm_valid=0, load_busy=0, word_count=0, err_overflow=0.
REQ-029 reset mid-LOAD or mid-FILL SHALL discard the partial load; tm_valid stays 0 until a completed load after reset release.

Configuration
REQ-030 Macro TM_LOADER_ZERO_FILL_EN defined SHALL include state FILL per REQ-021/REQ-023.
REQ-031 Macro TM_LOADER_ZERO_FILL_EN undefined SHALL omit FILL; in_last goes directly to DONE and stale slots persist.

Structure
REQ-032 Shared package tm_pkg SHALL hold INSN_SIZE, INSN_COUNT, TASK_MEM_DEPTH, TASK_MEM_WIDTH (=INSN_COUNT*INSN_SIZE), and the state encoding.
REQ-033 Row/column slot counter with wrap and final-slot flag SHALL be sub-module tm_loader_addr_ctr, shared by LOAD and FILL.

Verification
REQ-034 Reset, then start_load, stream 20 words 0x0001..0x0014 with in_last on 20th -> row0 insns 0..15 = 0x0001..0x0010, row1 insns 0..3 = 0x0011..0x0014, word_count=20, tm_valid=1.
REQ-035 With TM_LOADER_ZERO_FILL_EN, preload all 128 slots 0xFFFF, then load 3 words -> slots 3..127 read 0x0000 after 125 FILL cycles; without macro they read 0xFFFF.
REQ-036 Stream 128 words without in_last -> DONE after 128th, err_overflow=1, word_count=128; a 129th in_valid is ignored.
REQ-037 Hold in_valid high, toggle start_load at word 5 -> word 5 not accepted, word_count=0 next cycle, next word lands at row0 col0.
REQ-038 Assert reset low at word 10 of a load -> same cycle tm_valid=0, task_memory all 0, state IDLE; in_ready stays 0 until start_load.
REQ-039 Random in_valid gaps (50% duty) over a 40-word load -> image identical to gap-free load; in_ready never high outside LOAD.
